// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for one block-RAM port: whole-burst round-robin grants,
// forced hand-over after MAX_BURST beats, and a tag pipeline that steers read data.
module bram_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 2,   // must be >= 2
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              last0,
    input  logic              last1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              bram_en,
    output logic              bram_we,
    output logic              bram_regce,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_prio;
    logic [CNT_W-1:0]   r_beat_cnt;

    logic               w_own1;
    logic               w_ack;
    logic               w_wr;
    logic               w_last;
    logic               w_req_own;
    logic               w_req_oth;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    state_t             w_other_state;

    logic               r_bram_en;
    logic               r_bram_we;
    logic               r_issue_own;
    logic [ADDR_W-1:0]  r_bram_addr;
    logic [DATA_W-1:0]  r_bram_din;
    logic [RD_LAT-1:0]  r_tag_vld;
    logic [RD_LAT-1:0]  r_tag_own;

    assign w_own1        = (r_state == OWN1);
    assign ack0          = (r_state == OWN0) & req0;
    assign ack1          = w_own1 & req1;
    assign w_ack         = ack0 | ack1;
    assign w_wr          = w_own1 ? wr1    : wr0;
    assign w_last        = w_own1 ? last1  : last0;
    assign w_addr        = w_own1 ? addr1  : addr0;
    assign w_wdata       = w_own1 ? wdata1 : wdata0;
    assign w_req_own     = w_own1 ? req1   : req0;
    assign w_req_oth     = w_own1 ? req0   : req1;
    assign w_other_state = w_own1 ? OWN0   : OWN1;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            r_state    <= IDLE;
            r_prio     <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_beat_cnt <= '0;
                    if (req0 && req1) begin
                        r_state <= r_prio ? OWN1 : OWN0;
                    end else if (req0) begin
                        r_state <= OWN0;
                    end else if (req1) begin
                        r_state <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    // A dropped req ends the burst just like last does.
                    if (!w_req_own || w_last) begin
                        r_prio     <= ~w_own1;
                        r_state    <= w_req_oth ? w_other_state : IDLE;
                        r_beat_cnt <= '0;
                    end else if (r_beat_cnt == CNT_LAST && w_req_oth) begin
                        r_prio     <= ~w_own1;
                        r_state    <= w_other_state;
                        r_beat_cnt <= '0;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            r_bram_en   <= 1'b0;
            r_bram_we   <= 1'b0;
            r_issue_own <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
            r_tag_vld   <= '0;
            r_tag_own   <= '0;
        end else begin
            r_bram_en <= w_ack;
            r_bram_we <= w_ack & w_wr;
            if (w_ack) begin
                r_issue_own <= w_own1;
                r_bram_addr <= w_addr;
                r_bram_din  <= w_wdata;
            end
            // Owner tag travels with the beat, so later ownership changes cannot misroute it.
            r_tag_vld <= {r_tag_vld[RD_LAT-2:0], r_bram_en & ~r_bram_we};
            r_tag_own <= {r_tag_own[RD_LAT-2:0], r_issue_own};
        end
    end

    assign bram_en    = r_bram_en;
    assign bram_we    = r_bram_we;
    assign bram_addr  = r_bram_addr;
    assign bram_din   = r_bram_din;
    assign bram_regce = r_tag_vld[RD_LAT-2];
    assign rvalid0    = r_tag_vld[RD_LAT-1] & ~r_tag_own[RD_LAT-1];
    assign rvalid1    = r_tag_vld[RD_LAT-1] &  r_tag_own[RD_LAT-1];
    assign rdata      = reset_in ? bram_dout : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM model with output register, burst agents,
// a per-cycle reference model and directed scenarios with literal expectations.
module tb_bram_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          reset_in = 1'b0;
    logic          req0, req1, wr0, wr1, last0, last1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          bram_en, bram_we, bram_regce;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .MAX_BURST(MB)) dut (
        .clk(clk), .reset_in(reset_in),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .last0(last0), .last1(last1), .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .bram_en(bram_en), .bram_we(bram_we), .bram_regce(bram_regce),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
    );

    function automatic logic [7:0] init_val(input int a);
        logic [11:0] aa;
        aa = 12'(a);
        return aa[7:0] ^ {aa[11:8], aa[11:8]};
    endfunction

    // BRAM: array read on en, output register loaded on regce.
    logic [7:0] mem [4096];
    bit         mem_wr [4096];
    logic [7:0] b_lat = '0;
    logic [7:0] b_dout = '0;
    assign bram_dout = b_dout;
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                mem[bram_addr]    <= bram_din;
                mem_wr[bram_addr] <= 1'b1;
            end else begin
                b_lat <= mem_wr[bram_addr] ? mem[bram_addr] : init_val(int'(bram_addr));
            end
        end
        if (bram_regce) b_dout <= b_lat;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {int due; int own; int data;} rd_t;
    rd_t        q[$];
    logic [7:0] m_mem [4096];
    bit         m_wr [4096];
    int cyc = 0;
    int m_owner = -1;
    int m_prio = 0;
    int m_cnt = 0;
    int m_en = 0, m_we = 0, m_addr = 0, m_din = 0;

    always @(negedge clk) begin
        int e0, e1, rv0, rv1, rce, i, w, a, d, ri, li, ro;
        cyc++;
        if (!reset_in) begin
            chk("rst_ack0", ack0, 0);       chk("rst_ack1", ack1, 0);
            chk("rst_rvalid0", rvalid0, 0); chk("rst_rvalid1", rvalid1, 0);
            chk("rst_en", bram_en, 0);      chk("rst_we", bram_we, 0);
            chk("rst_regce", bram_regce, 0);
            chk("rst_addr", bram_addr, 0);  chk("rst_din", bram_din, 0);
            chk("rst_rdata", rdata, 0);
            m_owner = -1; m_prio = 0; m_cnt = 0;
            m_en = 0; m_we = 0; m_addr = 0; m_din = 0;
            q.delete();
        end else begin
            e0 = (m_owner == 0 && req0) ? 1 : 0;
            e1 = (m_owner == 1 && req1) ? 1 : 0;
            chk("ack0", ack0, e0);
            chk("ack1", ack1, e1);
            chk("bram_en", bram_en, m_en);
            chk("bram_we", bram_we, m_we);
            chk("bram_addr", bram_addr, m_addr);
            chk("bram_din", bram_din, m_din);
            rce = 0;
            foreach (q[k]) if (q[k].due == cyc + 1) rce = 1;
            chk("bram_regce", bram_regce, rce);
            rv0 = 0; rv1 = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                if (q[0].own == 0) rv0 = 1; else rv1 = 1;
                chk("rdata", rdata, q[0].data);
                void'(q.pop_front());
            end
            chk("rvalid0", rvalid0, rv0);
            chk("rvalid1", rvalid1, rv1);

            if (e0 || e1) begin
                i = e1;
                w = i ? wr1 : wr0;
                a = i ? addr1 : addr0;
                d = i ? wdata1 : wdata0;
                m_en = 1; m_we = w; m_addr = a; m_din = d;
                if (w != 0) begin
                    m_mem[a] = 8'(d); m_wr[a] = 1'b1;
                end else begin
                    q.push_back('{cyc + 3, i, m_wr[a] ? int'(m_mem[a]) : int'(init_val(a))});
                end
            end else begin
                m_en = 0; m_we = 0;
            end

            // Ownership rules: burst end, forced hand-over, otherwise count beats.
            if (m_owner < 0) begin
                m_cnt = 0;
                if (req0 && req1) m_owner = m_prio;
                else if (req0)    m_owner = 0;
                else if (req1)    m_owner = 1;
            end else begin
                ri = (m_owner == 1) ? req1 : req0;
                li = (m_owner == 1) ? last1 : last0;
                ro = (m_owner == 1) ? req0 : req1;
                if (!ri || li) begin
                    m_prio  = 1 - m_owner;
                    m_owner = ro ? 1 - m_owner : -1;
                    m_cnt   = 0;
                end else if (m_cnt == MB - 1 && ro) begin
                    m_prio  = 1 - m_owner;
                    m_owner = 1 - m_owner;
                    m_cnt   = 0;
                end else begin
                    m_cnt = (m_cnt + 1) % MB;
                end
            end
        end
    end

    // ---------------- burst agents ----------------
    bit a_wr [2][64];
    int a_addr [2][64];
    int a_len [2];
    int a_stop [2];
    int a_ptr [2];
    bit a_last [2];
    bit ack_seen [2];

    task automatic setup(input int r, input int n, input bit wr, input int base,
                         input bit uselast, input int stop);
        for (int k = 0; k < n; k++) begin
            a_wr[r][k]   = wr;
            a_addr[r][k] = base + k;
        end
        a_len[r] = n; a_stop[r] = stop; a_ptr[r] = 0;
        a_last[r] = uselast; ack_seen[r] = 1'b0;
    endtask

    task automatic clear_agents();
        for (int r = 0; r < 2; r++) begin
            a_len[r] = 0; a_stop[r] = 0; a_ptr[r] = 0;
            a_last[r] = 1'b0; ack_seen[r] = 1'b0;
        end
    endtask

    task automatic drive();
        int p0, p1;
        p0 = (a_ptr[0] < 64) ? a_ptr[0] : 63;
        p1 = (a_ptr[1] < 64) ? a_ptr[1] : 63;
        req0   = (a_ptr[0] < a_stop[0]);
        wr0    = a_wr[0][p0];
        addr0  = AW'(a_addr[0][p0]);
        wdata0 = DW'(a_addr[0][p0] ^ 'h3C);
        last0  = a_last[0] && (a_ptr[0] == a_len[0] - 1);
        req1   = (a_ptr[1] < a_stop[1]);
        wr1    = a_wr[1][p1];
        addr1  = AW'(a_addr[1][p1]);
        wdata1 = DW'(a_addr[1][p1] ^ 'h3C);
        last1  = a_last[1] && (a_ptr[1] == a_len[1] - 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++) if (ack_seen[r]) a_ptr[r]++;
        drive();
        @(negedge clk);
        #1;
        ack_seen[0] = ack0;
        ack_seen[1] = ack1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_in = 1'b0;
        clear_agents();
        drive();
        @(negedge clk);
        @(negedge clk);
        #2 reset_in = 1'b1;
    endtask

    initial begin
        int a0 [9], a1 [9];
        int e0 [9], e1 [9];
        int n0, n1, pre, c16, first1, resume, rv0n, rv1n, rv0c, rv1c, d0, d1;
        bit started1;
        clear_agents();
        drive();
        do_reset();

        // 1: single read
        setup(0, 1, 1'b0, 'h123, 1'b1, 1);
        tick(); chk("t1_idle_no_ack", ack0, 0);
        tick(); chk("t1_ack0", ack0, 1);
        tick(); chk("t1_bram_en", bram_en, 1); chk("t1_bram_addr", bram_addr, 'h123);
        tick(); chk("t1_rvalid_early", rvalid0, 0);
        tick(); chk("t1_rvalid0", rvalid0, 1); chk("t1_rdata", rdata, 'h32);
        chk("t1_rvalid1", rvalid1, 0);
        repeat (2) tick();
        $display("txn t1 single read done");

        // 2: contention, 3-beat write bursts
        do_reset();
        e0 = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
        e1 = '{0, 0, 0, 0, 1, 1, 1, 0, 0};
        setup(0, 3, 1'b1, 'h010, 1'b1, 3);
        setup(1, 3, 1'b1, 'h800, 1'b1, 3);
        for (int k = 0; k < 9; k++) begin
            tick(); a0[k] = ack0; a1[k] = ack1;
        end
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("t2_ack0_c%0d", k), a0[k], e0[k]);
            chk($sformatf("t2_ack1_c%0d", k), a1[k], e1[k]);
        end
        setup(0, 1, 1'b0, 'h020, 1'b1, 1);
        repeat (3) tick();
        setup(0, 1, 1'b0, 'h021, 1'b1, 1);
        setup(1, 1, 1'b0, 'h030, 1'b1, 1);
        tick(); chk("t2_rr_idle", ack0 | ack1, 0);
        tick(); chk("t2_rr_ack1_first", ack1, 1); chk("t2_rr_ack0_wait", ack0, 0);
        tick(); chk("t2_rr_ack0_next", ack0, 1);
        repeat (5) tick();
        $display("txn t2 contention and round-robin done");

        // 3: forced hand-over
        n0 = 0; n1 = 0; pre = 0; c16 = -1; first1 = -1; resume = -1;
        rv0n = 0; rv1n = 0; started1 = 1'b0;
        setup(0, 40, 1'b0, 'h300, 1'b1, 40);
        for (int k = 0; k < 80; k++) begin
            tick();
            if (rvalid0) rv0n++;
            if (rvalid1) rv1n++;
            if (ack1) begin
                n1++;
                if (first1 < 0) first1 = k;
            end
            if (ack0) begin
                if (first1 >= 0 && resume < 0) resume = int'(addr0) - 'h300;
                n0++;
                if (first1 < 0) pre++;
                if (n0 == 16) c16 = k;
                if (n0 == 5 && !started1) begin
                    setup(1, 3, 1'b1, 'h900, 1'b1, 3);
                    started1 = 1'b1;
                end
            end
        end
        chk("t3_beats_before_handover", pre, 16);
        chk("t3_ack1_next_cycle", first1 - c16, 1);
        chk("t3_resume_beat_index", resume, 16);
        chk("t3_ack0_total", n0, 40);
        chk("t3_ack1_total", n1, 3);
        chk("t3_rvalid0_total", rv0n, 40);
        chk("t3_rvalid1_total", rv1n, 0);
        $display("txn t3 forced hand-over done");

        // 4: reads straddling a switch
        do_reset();
        rv0c = -100; rv1c = -100; d0 = -1; d1 = -1;
        setup(0, 1, 1'b0, 'h100, 1'b1, 1);
        setup(1, 1, 1'b0, 'h200, 1'b1, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rvalid0) begin rv0c = k; d0 = rdata; end
            if (rvalid1) begin rv1c = k; d1 = rdata; end
        end
        chk("t4_rvalid0_cycle", rv0c, 4);
        chk("t4_rvalid1_follows", rv1c - rv0c, 1);
        chk("t4_rdata0", d0, 'h11);
        chk("t4_rdata1", d1, 'h22);
        $display("txn t4 interleaved reads done");

        // 5: req dropped mid-burst
        n0 = 0;
        setup(0, 5, 1'b0, 'h400, 1'b0, 2);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ack0) n0++;
            if (k == 3) chk("t5_no_ack_when_low", ack0, 0);
        end
        chk("t5_acks_before_drop", n0, 2);
        setup(0, 1, 1'b0, 'h410, 1'b1, 1);
        setup(1, 1, 1'b0, 'h420, 1'b1, 1);
        tick(); chk("t5_idle_after_drop", ack0 | ack1, 0);
        tick(); chk("t5_prio1_ack1", ack1, 1); chk("t5_prio1_ack0", ack0, 0);
        repeat (6) tick();
        $display("txn t5 dropped request done");

        // 6: reset during a read
        setup(0, 1, 1'b0, 'h555, 1'b1, 1);
        tick();
        tick(); chk("t6_ack0", ack0, 1);
        @(posedge clk);
        #2 reset_in = 1'b0;
        #1;
        chk("t6_async_ack0", ack0, 0);       chk("t6_async_ack1", ack1, 0);
        chk("t6_async_en", bram_en, 0);      chk("t6_async_we", bram_we, 0);
        chk("t6_async_regce", bram_regce, 0);
        chk("t6_async_addr", bram_addr, 0);  chk("t6_async_din", bram_din, 0);
        chk("t6_async_rv0", rvalid0, 0);     chk("t6_async_rv1", rvalid1, 0);
        chk("t6_async_rdata", rdata, 0);
        clear_agents();
        drive();
        @(negedge clk);
        @(negedge clk);
        #2 reset_in = 1'b1;
        rv0n = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (rvalid0 || rvalid1) rv0n++;
        end
        chk("t6_no_rvalid_after_reset", rv0n, 0);
        setup(0, 1, 1'b0, 'h556, 1'b1, 1);
        tick(); chk("t6_idle_latency", ack0, 0);
        tick(); chk("t6_grant", ack0, 1);
        repeat (5) tick();
        $display("txn t6 reset mid-operation done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
